// File: rtl/ps2_key_tracker_if.sv
// Bundles the signals between ps2_key_tracker and the rest of the system:
// the incoming scancode stream, the held-key bitmaps and the event FIFO
// handshake. The master side drives bytes and consumes events; the slave
// side is the tracker.
interface ps2_key_tracker_if;
    logic       code_valid;
    logic [7:0] code;
    logic       code_err;
    logic [4:0] p1keys;
    logic [4:0] p2keys;
    logic       evt_valid;
    logic [4:0] evt_data;
    logic       evt_ready;
    logic       evt_overflow;
    logic       ovf_clr;

    modport master (
        output code_valid, code, code_err, evt_ready, ovf_clr,
        input  p1keys, p2keys, evt_valid, evt_data, evt_overflow
    );

    modport slave (
        input  code_valid, code, code_err, evt_ready, ovf_clr,
        output p1keys, p2keys, evt_valid, evt_data, evt_overflow
    );
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 scancode decoder for a two-player keyboard layout. Tracks which game
// keys are held for each player, and reports every real key transition as an
// event through a small FIFO. Keyboard self-test / overrun bytes release all
// held keys and report a break event for each of them.
module ps2_key_tracker #(
    parameter int TIMEOUT_CYCLES = 25000,
    parameter int FIFO_DEPTH     = 4
) (
    input logic              clk,
    input logic              rst_n,
    ps2_key_tracker_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [9:0]       keys;        // {p2keys, p1keys}
    logic [9:0]       flush_mask;  // keys still owed a break event after a reset byte

    logic       flushing;
    logic       accept;
    logic       good;
    logic       is_reset_code;
    logic       is_ext;
    logic       map_hit;
    logic       map_player;
    logic [2:0] map_idx;
    logic [3:0] key_pos;
    logic [9:0] key_mask;
    logic       key_held;
    logic       decode_now;
    logic       decode_make;
    logic       key_change;
    logic [3:0] flush_pos;
    logic       flush_player;
    logic [2:0] flush_idx;
    logic       push_req;
    logic [4:0] push_data;

    // While break events for a reset byte are being emitted, incoming bytes are discarded.
    assign flushing      = |flush_mask;
    assign accept        = bus.code_valid && !flushing;
    assign good          = accept && !bus.code_err;
    assign is_reset_code = (bus.code == 8'hAA) || (bus.code == 8'hFC) ||
                           (bus.code == 8'h00) || (bus.code == 8'hFF);
    assign is_ext        = (state == EXT) || (state == EXT_BRK);

    // Map the current byte to a player/key, honouring the extended prefix.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        map_hit    = 1'b0;
        map_player = 1'b0;
        map_idx    = 3'd0;
        if (is_ext) begin
            unique case (bus.code)
                8'h75:   begin map_hit = 1'b1; map_idx = 3'd0; end
                8'h6B:   begin map_hit = 1'b1; map_idx = 3'd1; end
                8'h74:   begin map_hit = 1'b1; map_idx = 3'd2; end
                8'h72:   begin map_hit = 1'b1; map_idx = 3'd3; end
                default: ;
            endcase
        end else begin
            unique case (bus.code)
                8'h29:   begin map_hit = 1'b1; map_idx = 3'd4; end
                8'h1D:   begin map_hit = 1'b1; map_player = 1'b1; map_idx = 3'd0; end
                8'h1C:   begin map_hit = 1'b1; map_player = 1'b1; map_idx = 3'd1; end
                8'h1B:   begin map_hit = 1'b1; map_player = 1'b1; map_idx = 3'd2; end
                8'h23:   begin map_hit = 1'b1; map_player = 1'b1; map_idx = 3'd3; end
                8'h0D:   begin map_hit = 1'b1; map_player = 1'b1; map_idx = 3'd4; end
                default: ;
            endcase
        end
    end

    assign key_pos  = map_player ? ({1'b0, map_idx} + 4'd5) : {1'b0, map_idx};
    assign key_mask = 10'd1 << key_pos;
    assign key_held = |(keys & key_mask);

    // Decide whether this byte is a final make/break byte rather than a prefix.
    always_comb begin
        decode_now  = 1'b0;
        decode_make = 1'b0;
        if (good && !is_reset_code) begin
            unique case (state)
                IDLE: if (bus.code != 8'hE0 && bus.code != 8'hF0) begin
                    decode_now  = 1'b1;
                    decode_make = 1'b1;
                end
                EXT: if (bus.code != 8'hF0) begin
                    decode_now  = 1'b1;
                    decode_make = 1'b1;
                end
                BRK, EXT_BRK: decode_now = 1'b1;
                default: ;
            endcase
        end
    end

    // Repeat makes of a held key and breaks of a released key are not transitions.
    assign key_change = decode_now && map_hit && (decode_make != key_held);

    // Lowest pending bit of the flush mask is the next break event to emit.
    always_comb begin
        flush_pos = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (flush_mask[i]) flush_pos = 4'(i);
        end
    end

    assign flush_player = (flush_pos >= 4'd5);
    assign flush_idx    = flush_player ? 3'(flush_pos - 4'd5) : flush_pos[2:0];
    assign push_req     = flushing || key_change;
    assign push_data    = flushing ? {flush_player, flush_idx, 1'b0}
                                   : {map_player, map_idx, decode_make};

    // Prefix FSM, inter-byte timeout, key bitmaps and reset-byte flush sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            keys       <= '0;
            flush_mask <= '0;
        end else begin
            // NOTE: all state here is updated with <= so every branch sees the pre-edge values.
            if (flushing) flush_mask <= flush_mask & (flush_mask - 10'd1);

            if (bus.code_valid) begin
                tmo_cnt <= '0;
            end else if (state != IDLE) begin
                if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state   <= IDLE;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end

            if (accept) begin
                if (bus.code_err) begin
                    state <= IDLE;
                end else if (is_reset_code) begin
                    state      <= IDLE;
                    keys       <= '0;
                    flush_mask <= keys;
                end else begin
                    unique case (state)
                        IDLE:    state <= (bus.code == 8'hE0) ? EXT :
                                          (bus.code == 8'hF0) ? BRK : IDLE;
                        EXT:     state <= (bus.code == 8'hF0) ? EXT_BRK : IDLE;
                        default: state <= IDLE;
                    endcase
                end
                if (key_change) begin
                    keys <= decode_make ? (keys | key_mask) : (keys & ~key_mask);
                end
            end
        end
    end

    assign bus.p1keys = keys[4:0];
    assign bus.p2keys = keys[9:5];

    // Event FIFO: pointers carry one extra wrap bit to tell full from empty.
    logic [4:0]     mem [FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           empty;
    logic           full;
    logic           pop;
    logic           push;
    logic           drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop   = !empty && bus.evt_ready;
    assign push  = push_req && (!full || pop);
    assign drop  = push_req && full && !pop;

    // FIFO pointers and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            bus.evt_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop)             bus.evt_overflow <= 1'b1;
            else if (bus.ovf_clr) bus.evt_overflow <= 1'b0;
        end
    end

    // Event storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the empty flag masks stale contents.
        if (push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

    assign bus.evt_valid = !empty;
    assign bus.evt_data  = empty ? 5'd0 : mem[rd_ptr[PTR_W-1:0]];
endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle from the active edge.
module tb_ps2_key_tracker;
    localparam int TMO = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    ps2_key_tracker_if bus ();

    ps2_key_tracker #(.TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; presents one byte for exactly one rising edge.
    task automatic send(input logic [7:0] b, input logic err = 1'b0);
        bus.code_valid = 1'b1;
        bus.code       = b;
        bus.code_err   = err;
        @(negedge clk);
        bus.code_valid = 1'b0;
        bus.code_err   = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [4:0] exp);
        check({tag, "_valid"}, 32'(bus.evt_valid), 32'd1);
        check(tag, 32'(bus.evt_data), 32'(exp));
        bus.evt_ready = 1'b1;
        @(negedge clk);
        bus.evt_ready = 1'b0;
    endtask

    task automatic clear_ovf();
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.code_valid = 1'b0;
        bus.code       = 8'h00;
        bus.code_err   = 1'b0;
        bus.evt_ready  = 1'b0;
        bus.ovf_clr    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_p1", 32'(bus.p1keys), 32'd0);
        check("rst_p2", 32'(bus.p2keys), 32'd0);
        check("rst_valid", 32'(bus.evt_valid), 32'd0);
        check("rst_data", 32'(bus.evt_data), 32'd0);
        check("rst_ovf", 32'(bus.evt_overflow), 32'd0);

        // Byte in the very first cycle after release is accepted.
        rst_n = 1'b1;
        send(8'h29);
        check("first_p1", 32'(bus.p1keys), 32'b10000);
        send(8'hF0); send(8'h29);
        check("first_brk_p1", 32'(bus.p1keys), 32'd0);
        pop_expect("first_mk", 5'b01001);
        pop_expect("first_bk", 5'b01000);

        // Extended make then extended break of P1 up.
        send(8'hE0); send(8'h75);
        check("ext_mk_p1", 32'(bus.p1keys), 32'b00001);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("ext_bk_p1", 32'(bus.p1keys), 32'd0);
        pop_expect("ext_mk_evt", 5'b00001);
        pop_expect("ext_bk_evt", 5'b00000);
        check("ext_empty", 32'(bus.evt_valid), 32'd0);

        // Typematic repeats produce no extra events.
        send(8'h1D); send(8'h1D); send(8'h1D); send(8'h1C);
        check("rep_p2", 32'(bus.p2keys), 32'b00011);
        pop_expect("rep_e0", 5'b10001);
        pop_expect("rep_e1", 5'b10011);
        check("rep_only2", 32'(bus.evt_valid), 32'd0);
        send(8'hF0); send(8'h1D); send(8'hF0); send(8'h1C);
        send(8'hF0); send(8'h1C);   // break of a released key: nothing
        pop_expect("rep_b0", 5'b10000);
        pop_expect("rep_b1", 5'b10010);
        check("rep_b_only2", 32'(bus.evt_valid), 32'd0);

        // Prefix timeout: exactly TMO idle cycles returns to IDLE, 75 is then keypad.
        send(8'hE0);
        repeat (TMO) @(negedge clk);
        send(8'h75);
        check("tmo_p1", 32'(bus.p1keys), 32'd0);
        check("tmo_noevt", 32'(bus.evt_valid), 32'd0);
        // One cycle short of the timeout the prefix is still live.
        send(8'hE0);
        repeat (TMO - 1) @(negedge clk);
        send(8'h75);
        check("tmo_edge_p1", 32'(bus.p1keys), 32'b00001);
        send(8'hE0); send(8'hF0); send(8'h75);
        pop_expect("tmo_edge_mk", 5'b00001);
        pop_expect("tmo_edge_bk", 5'b00000);

        // Overflow: five makes into a four-entry FIFO.
        send(8'h29); send(8'h1D); send(8'h1C); send(8'h1B);
        check("ovf_not_yet", 32'(bus.evt_overflow), 32'd0);
        send(8'h23);
        check("ovf_set", 32'(bus.evt_overflow), 32'd1);
        check("ovf_p2", 32'(bus.p2keys), 32'b01111);
        clear_ovf();
        check("ovf_clr", 32'(bus.evt_overflow), 32'd0);
        pop_expect("ovf_e0", 5'b01001);
        pop_expect("ovf_e1", 5'b10001);
        pop_expect("ovf_e2", 5'b10011);
        pop_expect("ovf_e3", 5'b10101);
        check("ovf_drained", 32'(bus.evt_valid), 32'd0);

        // Self-test byte with five keys held: bitmaps clear next cycle, one
        // break per cycle, the fifth overflows, a byte sent meanwhile is ignored.
        send(8'hAA);
        check("aa_p1", 32'(bus.p1keys), 32'd0);
        check("aa_p2", 32'(bus.p2keys), 32'd0);
        send(8'h0D);
        repeat (6) @(negedge clk);
        check("aa_discard", 32'(bus.p2keys), 32'd0);
        check("aa_ovf", 32'(bus.evt_overflow), 32'd1);
        clear_ovf();
        pop_expect("aa_e0", 5'b01000);
        pop_expect("aa_e1", 5'b10000);
        pop_expect("aa_e2", 5'b10010);
        pop_expect("aa_e3", 5'b10100);
        check("aa_drained", 32'(bus.evt_valid), 32'd0);

        // Push and pop together while full: push accepted, no overflow.
        send(8'h1D); send(8'h1C); send(8'h1B); send(8'h23);
        bus.evt_ready = 1'b1;
        send(8'h0D);
        bus.evt_ready = 1'b0;
        check("full_pp_ovf", 32'(bus.evt_overflow), 32'd0);
        pop_expect("full_pp_e0", 5'b10011);
        pop_expect("full_pp_e1", 5'b10101);
        pop_expect("full_pp_e2", 5'b10111);
        pop_expect("full_pp_e3", 5'b11001);
        check("full_pp_empty", 32'(bus.evt_valid), 32'd0);

        // Push and pop together with one entry.
        send(8'h29);
        send(8'hF0);
        bus.evt_ready = 1'b1;
        send(8'h29);
        bus.evt_ready = 1'b0;
        pop_expect("one_pp", 5'b01000);
        check("one_pp_empty", 32'(bus.evt_valid), 32'd0);

        // Overrun byte releases the remaining P2 keys; consumer drains live.
        bus.evt_ready = 1'b1;
        send(8'hFF);
        repeat (8) @(negedge clk);
        bus.evt_ready = 1'b0;
        check("ff_p2", 32'(bus.p2keys), 32'd0);
        check("ff_empty", 32'(bus.evt_valid), 32'd0);

        // Fire keys of both players held, then self-test pass.
        send(8'h29); send(8'h0D);
        pop_expect("fire_mk1", 5'b01001);
        pop_expect("fire_mk2", 5'b11001);
        send(8'hAA);
        check("fire_p1", 32'(bus.p1keys), 32'd0);
        check("fire_p2", 32'(bus.p2keys), 32'd0);
        repeat (3) @(negedge clk);
        pop_expect("fire_bk1", 5'b01000);
        pop_expect("fire_bk2", 5'b11000);
        check("fire_empty", 32'(bus.evt_valid), 32'd0);

        // Errored F0 is not a break prefix.
        send(8'hF0, 1'b1);
        send(8'h1D);
        check("err_p2", 32'(bus.p2keys), 32'b00001);
        pop_expect("err_evt", 5'b10001);

        // Reset after a break prefix: prefix is forgotten.
        send(8'hF0);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_p2", 32'(bus.p2keys), 32'd0);
        check("mid_rst_valid", 32'(bus.evt_valid), 32'd0);
        rst_n = 1'b1;
        send(8'h1D);
        check("mid_rst_make", 32'(bus.p2keys), 32'b00001);
        pop_expect("mid_rst_evt", 5'b10001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
